piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_hold_buf.sv | 37 +++
 rtl/piso_serializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
// PISO_PARITY_EN (when defined) adds an even-parity bit to every frame.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer: takes a word while empty, releases it on pop.
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         pop
);

  logic         full;
  logic [W-1:0] data;

  // pop and write never coincide: writes need full=0, pops need full=1
  always_ff @(posedge clk) begin
    if (!resetn) begin
      full <= 1'b0;
      data <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with a one-word skid buffer for gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after bit 0 of each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_WIDTH - 1);

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] sreg, sreg_nx;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  load, fin, accept;
  logic                  buf_wr, buf_pop, buf_ready, buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  dout_nx, vld_nx, last_nx;
`ifdef PISO_PARITY_EN
  logic                  par, par_nx;
`endif

  // Ready depends only on buffer occupancy (and reset), never on din_valid.
  assign din_ready = resetn & buf_ready;
  assign accept    = din_valid & din_ready;

  piso_hold_buf #(.W(DATA_WIDTH)) u_hold (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (din),
    .in_valid  (buf_wr),
    .in_ready  (buf_ready),
    .out_data  (buf_data),
    .out_valid (buf_valid),
    .pop       (buf_pop)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sreg_nx   = sreg;
    load      = 1'b0;
    load_word = din;
    fin       = 1'b0;
    buf_pop   = 1'b0;
`ifdef PISO_PARITY_EN
    par_nx    = par;
`endif

    case (state)
      IDLE: load = accept;
      SHIFT: begin
        if (cnt == '0) begin
`ifdef PISO_PARITY_EN
          state_nx = PARITY;
`else
          fin = 1'b1;
`endif
        end else begin
          cnt_nx  = cnt - 1'b1;
          sreg_nx = sreg << 1;
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: fin = 1'b1;
`endif
      default: state_nx = IDLE;
    endcase

    // Final-bit cycle: buffered word has priority, else a word arriving now.
    if (fin) begin
      if (buf_valid) begin
        load      = 1'b1;
        load_word = buf_data;
        buf_pop   = 1'b1;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sreg_nx  = '0;
      end
    end

    buf_wr = accept && (state != IDLE) && !fin;

    if (load) begin
      state_nx = SHIFT;
      cnt_nx   = CNT_TOP;
      sreg_nx  = load_word;
`ifdef PISO_PARITY_EN
      par_nx   = ^load_word;
`endif
    end

    vld_nx  = (state_nx != IDLE);
`ifdef PISO_PARITY_EN
    dout_nx = (state_nx == SHIFT) ? sreg_nx[DATA_WIDTH-1] :
              (state_nx == PARITY) ? par_nx : 1'b0;
    last_nx = (state_nx == PARITY);
`else
    dout_nx = (state_nx == SHIFT) ? sreg_nx[DATA_WIDTH-1] : 1'b0;
    last_nx = (state_nx == SHIFT) && (cnt_nx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sreg       <= sreg_nx;
      dout       <= dout_nx;
      dout_valid <= vld_nx;
      dout_last  <= last_nx;
`ifdef PISO_PARITY_EN
      par        <= par_nx;
`endif
    end
  end

endmodule
